// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike core slice.
package risc_v_mike_pkg;

    localparam int unsigned DATA_32_W = 32;
    localparam int unsigned PC_W = 32;
    localparam int unsigned IMEM_DEPTH_WORDS = 1024;

    localparam logic [PC_W-1:0] MEM_MAP_TEXT_LOWER_LIMIT = 32'h0040_0000;

    typedef logic [PC_W-1:0] t_pc_addr;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_RELEASE = 2'd3
    } t_imem_ld_state;

endpackage

// File: rtl/risc_v_mike_byte_packer.sv
// Assembles accepted loader bytes little-endian into 32-bit words.
module risc_v_mike_byte_packer
    import risc_v_mike_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_fire,
    input  logic [7:0]           byte_data,
    output logic [DATA_32_W-1:0] word_c,
    output logic                 word_valid_c
);

    logic [1:0]  byte_cnt;
    logic [23:0] lanes;

    // The fourth byte is never stored; it is forwarded directly into the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (byte_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    lanes[7:0]   <= byte_data;
                2'd1:    lanes[15:8]  <= byte_data;
                2'd2:    lanes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    assign word_c       = {byte_data, lanes};
    assign word_valid_c = byte_fire && (byte_cnt == 2'd3);

endmodule

// File: rtl/risc_v_mike_imem_load_ctrl.sv
// Arbitrates instruction memory between core fetch and the byte-stream program loader.
module risc_v_mike_imem_load_ctrl
    import risc_v_mike_pkg::*;
#(
    parameter  int unsigned IMEM_DEPTH = IMEM_DEPTH_WORDS,
    localparam int unsigned IDX_W      = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_start,
    input  logic [IDX_W:0]       ld_len_words,
    input  logic                 ld_byte_valid,
    input  logic [7:0]           ld_byte,
    output logic                 ld_byte_ready,
    output logic                 ld_busy,
    output logic                 ld_done,
    output logic                 ld_error,
    output logic [DATA_32_W-1:0] ld_checksum,
    output logic                 core_hold,
    input  logic                 fetch_req,
    input  t_pc_addr             fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_misalign,
    output logic [IDX_W-1:0]     imem_idx,
    output logic                 imem_wr_en,
    output logic [DATA_32_W-1:0] imem_wr_data
);

    t_imem_ld_state       state;
    logic [IDX_W:0]       len_q;
    logic [IDX_W:0]       word_cnt;
    logic                 len_bad_c;
    logic                 start_ok_c;
    logic                 fetch_en_c;
    t_pc_addr             fetch_off_c;
    logic [DATA_32_W-1:0] word_c;
    logic                 word_valid_c;

    assign len_bad_c  = (ld_len_words == '0) || (ld_len_words > (IDX_W+1)'(IMEM_DEPTH));
    assign start_ok_c = (state == LD_IDLE) && ld_start && !len_bad_c;

    risc_v_mike_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_ok_c),
        .byte_fire    (ld_byte_valid && ld_byte_ready),
        .byte_data    (ld_byte),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Load sequencer; all loader-side outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LD_IDLE;
            len_q         <= '0;
            word_cnt      <= '0;
            ld_byte_ready <= 1'b0;
            ld_busy       <= 1'b0;
            ld_done       <= 1'b0;
            ld_error      <= 1'b0;
            ld_checksum   <= '0;
            core_hold     <= 1'b0;
            imem_wr_en    <= 1'b0;
            imem_wr_data  <= '0;
        end else begin
            ld_done    <= 1'b0;
            ld_error   <= 1'b0;
            imem_wr_en <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (ld_start) begin
                        if (len_bad_c) begin
                            ld_error <= 1'b1;
                        end else begin
                            len_q         <= ld_len_words;
                            word_cnt      <= '0;
                            ld_checksum   <= '0;
                            ld_busy       <= 1'b1;
                            core_hold     <= 1'b1;
                            ld_byte_ready <= 1'b1;
                            state         <= LD_COLLECT;
                        end
                    end
                end
                LD_COLLECT: begin
                    if (word_valid_c) begin
                        ld_byte_ready <= 1'b0;
                        imem_wr_en    <= 1'b1;
                        imem_wr_data  <= word_c;
                        state         <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    ld_checksum <= ld_checksum + imem_wr_data;
                    word_cnt    <= word_cnt + (IDX_W+1)'(1);
                    if (word_cnt + (IDX_W+1)'(1) == len_q) begin
                        ld_done <= 1'b1;
                        state   <= LD_RELEASE;
                    end else begin
                        ld_byte_ready <= 1'b1;
                        state         <= LD_COLLECT;
                    end
                end
                LD_RELEASE: begin
                    ld_busy   <= 1'b0;
                    core_hold <= 1'b0;
                    state     <= LD_IDLE;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

    // Fetch pass-through; forced quiet while held or in reset.
    assign fetch_en_c     = rst && !core_hold;
    assign fetch_off_c    = fetch_addr - MEM_MAP_TEXT_LOWER_LIMIT;
    assign fetch_gnt      = fetch_en_c && fetch_req;
    assign fetch_misalign = fetch_en_c && fetch_req && (|fetch_addr[1:0]);

    always_comb begin
        imem_idx = '0;
        if (core_hold) begin
            imem_idx = word_cnt[IDX_W-1:0];
        end else if (fetch_en_c) begin
            imem_idx = IDX_W'(fetch_off_c >> 2);
        end
    end

endmodule

// File: tb/tb_risc_v_mike_imem_load_ctrl.sv
// Directed bench with a write scoreboard for the instruction-memory load controller.
module tb_risc_v_mike_imem_load_ctrl;
    import risc_v_mike_pkg::*;

    localparam int unsigned IDX_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_start;
    logic [IDX_W:0]    ld_len_words;
    logic              ld_byte_valid;
    logic [7:0]        ld_byte;
    logic              ld_byte_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_error;
    logic [31:0]       ld_checksum;
    logic              core_hold;
    logic              fetch_req;
    t_pc_addr          fetch_addr;
    logic              fetch_gnt;
    logic              fetch_misalign;
    logic [IDX_W-1:0]  imem_idx;
    logic              imem_wr_en;
    logic [31:0]       imem_wr_data;

    int errors = 0;
    int checks = 0;
    logic [41:0] exp_q[$];

    risc_v_mike_imem_load_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ld_start       (ld_start),
        .ld_len_words   (ld_len_words),
        .ld_byte_valid  (ld_byte_valid),
        .ld_byte        (ld_byte),
        .ld_byte_ready  (ld_byte_ready),
        .ld_busy        (ld_busy),
        .ld_done        (ld_done),
        .ld_error       (ld_error),
        .ld_checksum    (ld_checksum),
        .core_hold      (core_hold),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_gnt      (fetch_gnt),
        .fetch_misalign (fetch_misalign),
        .imem_idx       (imem_idx),
        .imem_wr_en     (imem_wr_en),
        .imem_wr_data   (imem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [IDX_W-1:0] idx, input logic [31:0] data);
        exp_q.push_back({idx, data});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ld_byte_valid = 1'b1;
        ld_byte       = b;
        while (!ld_byte_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("byte_ready_timeout", 64'd0, 64'd1);
        step();
        ld_byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [IDX_W:0] len);
        ld_start     = 1'b1;
        ld_len_words = len;
        step();
        ld_start     = 1'b0;
    endtask

    // Scoreboard: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'd0, imem_idx, imem_wr_data}, 64'd0);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                check("wr_idx", 64'(imem_idx), 64'(e[41:32]));
                check("wr_data", 64'(imem_wr_data), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        ld_start = 1'b0;
        ld_len_words = '0;
        ld_byte_valid = 1'b0;
        ld_byte = '0;
        fetch_req = 1'b1;
        fetch_addr = MEM_MAP_TEXT_LOWER_LIMIT + 32'h10;
        #12;
        check("rst_busy", 64'(ld_busy), 64'd0);
        check("rst_hold", 64'(core_hold), 64'd0);
        check("rst_ready", 64'(ld_byte_ready), 64'd0);
        check("rst_gnt", 64'(fetch_gnt), 64'd0);
        check("rst_idx", 64'(imem_idx), 64'd0);
        check("rst_cksum", 64'(ld_checksum), 64'd0);
        fetch_req = 1'b0;
        step();
        rst = 1'b1;
        step();

        // 1: two-word load, back-to-back bytes
        push_write(10'd0, 32'h0010_0413);
        push_write(10'd1, 32'h0020_0293);
        start_load(11'd2);
        check("t1_busy", 64'(ld_busy), 64'd1);
        check("t1_hold", 64'(core_hold), 64'd1);
        send_byte(8'h13); send_byte(8'h04); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
        check("t1_done_early", 64'(ld_done), 64'd0);
        step();
        check("t1_done", 64'(ld_done), 64'd1);
        check("t1_cksum", 64'(ld_checksum), 64'h0030_06A6);
        step();
        check("t1_done_pulse", 64'(ld_done), 64'd0);
        check("t1_busy_end", 64'(ld_busy), 64'd0);
        check("t1_cksum_hold", 64'(ld_checksum), 64'h0030_06A6);

        // 2: one-word load with gaps between bytes
        push_write(10'd0, 32'h4433_2211);
        start_load(11'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_ready_gap", 64'(ld_byte_ready), 64'd1);
            check("t2_hold_gap", 64'(core_hold), 64'd1);
            send_byte(8'((i + 1) * 8'h11));
        end
        check("t2_ready_write", 64'(ld_byte_ready), 64'd0);
        check("t2_hold_write", 64'(core_hold), 64'd1);
        step();
        check("t2_done", 64'(ld_done), 64'd1);
        check("t2_hold_release", 64'(core_hold), 64'd1);
        step();
        check("t2_hold_idle", 64'(core_hold), 64'd0);
        check("t2_cksum", 64'(ld_checksum), 64'h4433_2211);

        // 3: bad lengths
        start_load(11'd0);
        check("t3_err0", 64'(ld_error), 64'd1);
        check("t3_busy0", 64'(ld_busy), 64'd0);
        step();
        check("t3_err0_pulse", 64'(ld_error), 64'd0);
        start_load(11'd1025);
        check("t3_err1025", 64'(ld_error), 64'd1);
        check("t3_ready1025", 64'(ld_byte_ready), 64'd0);
        check("t3_hold1025", 64'(core_hold), 64'd0);
        step();
        check("t3_cksum_kept", 64'(ld_checksum), 64'h4433_2211);

        // 4: fetch pass-through and blocking
        fetch_req = 1'b1;
        fetch_addr = MEM_MAP_TEXT_LOWER_LIMIT + 32'h10;
        #1;
        check("t4_gnt", 64'(fetch_gnt), 64'd1);
        check("t4_idx", 64'(imem_idx), 64'd4);
        check("t4_mis0", 64'(fetch_misalign), 64'd0);
        fetch_addr = MEM_MAP_TEXT_LOWER_LIMIT + 32'h12;
        #1;
        check("t4_mis1", 64'(fetch_misalign), 64'd1);
        fetch_addr = MEM_MAP_TEXT_LOWER_LIMIT + 32'h10;
        push_write(10'd0, 32'h0000_0001);
        start_load(11'd1);
        check("t4_gnt_held", 64'(fetch_gnt), 64'd0);
        fetch_addr = MEM_MAP_TEXT_LOWER_LIMIT + 32'h12;
        #1;
        check("t4_mis_held", 64'(fetch_misalign), 64'd0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        step();
        step();
        fetch_req = 1'b0;

        // 5: ld_start during a load is ignored
        push_write(10'd0, 32'hDEAD_BEEF);
        push_write(10'd1, 32'h0000_0002);
        start_load(11'd2);
        send_byte(8'hEF); send_byte(8'hBE);
        start_load(11'd1);
        check("t5_no_err", 64'(ld_error), 64'd0);
        check("t5_busy", 64'(ld_busy), 64'd1);
        send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        step();
        check("t5_done", 64'(ld_done), 64'd1);
        check("t5_cksum", 64'(ld_checksum), 64'hDEAD_BEF1);
        step();

        // 6: reset mid-word, then a fresh load
        push_write(10'd0, 32'h1234_5678);
        start_load(11'd2);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h99); send_byte(8'h88);
        #2;
        rst = 1'b0;
        #1;
        check("t6_hold_async", 64'(core_hold), 64'd0);
        check("t6_busy_async", 64'(ld_busy), 64'd0);
        check("t6_ready_async", 64'(ld_byte_ready), 64'd0);
        check("t6_cksum_async", 64'(ld_checksum), 64'd0);
        step();
        rst = 1'b1;
        step();
        push_write(10'd0, 32'hDDCC_BBAA);
        start_load(11'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        step();
        check("t6_done", 64'(ld_done), 64'd1);
        check("t6_cksum", 64'(ld_checksum), 64'hDDCC_BBAA);
        step();
        step();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_imem_load_ctrl.md
Name: risc_v_mike_imem_load_ctrl

Overview:
Sequences the writable instruction memory between two users: the core fetch path and a byte-stream program loader (UART/debug side).
- While a load runs, the core is held and fetch is blocked.
- Bytes are assembled little-endian into 32-bit words, written to consecutive word indices from 0, and summed into a running checksum.
- Outside a load, fetch addresses are translated (text base subtracted, word index) and passed straight through to the memory.

Parameters:
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory
IDX_W, $clog2(IMEM_DEPTH), word-index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ld_start  in  1  pulse: begin load of ld_len_words words
ld_len_words  in  IDX_W+1  word count, sampled on accepted ld_start
ld_byte_valid  in  1  loader byte available
ld_byte  in  8  loader byte
ld_byte_ready  out  1  byte accepted when valid&ready
ld_busy  out  1  load in progress
ld_done  out  1  one-cycle pulse, load completed
ld_error  out  1  one-cycle pulse, bad length
ld_checksum  out  32  mod-2^32 sum of words written in last load
core_hold  out  1  stall/hold request to core
fetch_req  in  1  core fetch request
fetch_addr  in  t_pc_addr  byte PC
fetch_gnt  out  1  fetch served this cycle
fetch_misalign  out  1  fetch_req with PC not word-aligned
imem_idx  out  IDX_W  memory word index (fetch or write)
imem_wr_en  out  1  memory write strobe
imem_wr_data  out  32  memory write data

Behaviour:
Reset (rst=0, async): state IDLE; all outputs 0; word counter, byte counter, assembly register and checksum cleared.

FSM states: IDLE, COLLECT, WRITE, RELEASE.
- IDLE + ld_start:
  - ld_len_words==0 or >IMEM_DEPTH: pulse ld_error next cycle, stay IDLE.
  - Otherwise: latch length, clear word counter and checksum, go COLLECT, assert ld_busy and core_hold.
- COLLECT:
  - ld_byte_ready=1. Each handshake stores the byte at lane byte_cnt (byte 0 -> bits[7:0]) and increments byte_cnt.
  - On the 4th byte, go WRITE.
  - Idle cycles (valid=0) are allowed indefinitely.
- WRITE (exactly 1 cycle):
  - ld_byte_ready=0; imem_wr_en=1; imem_idx=word counter; imem_wr_data=assembled word.
  - checksum += word; word counter ++; byte_cnt=0.
  - If word counter+1 == length, go RELEASE; else go COLLECT.
- RELEASE (1 cycle): ld_done pulses, ld_busy=0, core_hold=0 from next cycle; go IDLE.
- Throughput: 4 bytes per 5 cycles minimum. Latency from last byte to ld_done: 2 cycles.
- ld_start while not IDLE is ignored (no error).
- Fetch path:
  - When core_hold=0: fetch_gnt=fetch_req (combinational); imem_idx=(fetch_addr-MEM_MAP_TEXT_LOWER_LIMIT)>>2, truncated to IDX_W; fetch_misalign=fetch_req & |addr[1:0].
  - When core_hold=1: fetch_gnt=0 and fetch_misalign=0.
- Wrap-around: the word counter never exceeds length-1, so there is no wrap. The checksum wraps mod 2^32.
- ld_checksum holds its value after ld_done until the next accepted ld_start.
- Reset mid-load: immediate abort, memory contents already written are retained (memory is not reset by this block), core_hold drops asynchronously.

Decomposition:
- risc_v_mike_pkg gets `t_imem_ld_state` (enum IDLE/COLLECT/WRITE/RELEASE) and `IMEM_DEPTH_WORDS` (1024). It reuses t_pc_addr, DATA_32_W and MEM_MAP_TEXT_LOWER_LIMIT.
- FFs use the header flop macros with an active-low async variant.
- One sub-module: risc_v_mike_byte_packer (byte handshake -> 32-bit word + word_valid).

Test Plan:
1. Reset release, ld_start with len=2, bytes 13,04,10,00,93,02,20,00 back-to-back -> writes idx0=0x00100413, idx1=0x00200293; ld_done 2 cycles after last byte; ld_checksum=0x003006A6.
2. Load of len=1 with byte_valid toggling every other cycle -> single write at idx0; ld_byte_ready low only in the WRITE cycle; core_hold high from start through RELEASE.
3. ld_start with len=0, then len=1025 -> ld_error pulse each, state stays IDLE, ld_busy=0, no imem_wr_en.
4. Idle, fetch_req with fetch_addr=MEM_MAP_TEXT_LOWER_LIMIT+0x10 -> fetch_gnt=1, imem_idx=4, fetch_misalign=0. With +0x12 -> fetch_misalign=1. During a load, same request -> fetch_gnt=0.
5. ld_start asserted mid-load -> ignored; the original length completes unchanged.
6. rst asserted after 2 bytes of word 1 -> outputs 0 immediately. New load of len=1 afterwards writes idx0 with fresh bytes only (no stale lane data).
